// File: rtl/slave_spi_reg_ctrl_if.sv
// Byte-level link between an SPI slave shifter, the register-access controller
// and the register file it drives.
interface slave_spi_reg_ctrl_if;
   logic       SyncCS_i;
   logic [7:0] RxData_i;
   logic       RxDone_i;
   logic [7:0] TxData_o;
   logic [6:0] RegAddr_o;
   logic [7:0] RegWrData_o;
   logic       RegWrite_o;
   logic       RegRead_o;
   logic [7:0] RegRdData_i;
   logic       Busy_o;
   logic [7:0] ByteCount_o;

   modport slave (
      input  SyncCS_i, RxData_i, RxDone_i, RegRdData_i,
      output TxData_o, RegAddr_o, RegWrData_o, RegWrite_o, RegRead_o, Busy_o, ByteCount_o
   );

   modport master (
      output SyncCS_i, RxData_i, RxDone_i, RegRdData_i,
      input  TxData_o, RegAddr_o, RegWrData_o, RegWrite_o, RegRead_o, Busy_o, ByteCount_o
   );
endinterface

// File: rtl/slave_spi_reg_ctrl.sv
// Turns SPI frames (command byte, then data bytes) into register write/read
// strobes and feeds read data back to the shifter for the following byte.
module slave_spi_reg_ctrl #(
   parameter logic [7:0]  STATUS_BYTE = 8'hA5,
   parameter int unsigned AUTO_INC    = 32'd1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   slave_spi_reg_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CMD        = 3'd1,
      ST_WRITE      = 3'd2,
      ST_READ_REQ   = 3'd3,
      ST_READ_LATCH = 3'd4,
      ST_READ_WAIT  = 3'd5
   } state_t;

   function automatic logic [6:0] addr_step(input logic [6:0] addr);
      if (AUTO_INC != 32'd0) begin
         addr_step = addr + 7'd1;
      end else begin
         addr_step = addr;
      end
   endfunction

   state_t     state_r;
   state_t     state_s;
   logic       cs_r;
   logic       cs_fall_s;
   logic       cs_rise_s;
   logic       cmd_load_s;
   logic       wr_req_s;
   logic       rd_req_s;
   logic       latch_s;
   logic       count_s;

   logic [7:0] tx_data_r;
   logic [6:0] reg_addr_r;
   logic [7:0] wr_data_r;
   logic       reg_write_r;
   logic       reg_read_r;
   logic       busy_r;
   logic [7:0] byte_count_r;

   // CS edge detection against the single internal CS register
   always_comb begin
      cs_fall_s = cs_r & ~bus.SyncCS_i;
      cs_rise_s = ~cs_r & bus.SyncCS_i;
      count_s   = bus.RxDone_i & ~bus.SyncCS_i & (state_r != ST_IDLE);
   end

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and one-cycle action requests; CS edges override every state
   always_comb begin
      state_s    = state_r;
      cmd_load_s = 1'b0;
      wr_req_s   = 1'b0;
      rd_req_s   = 1'b0;
      latch_s    = 1'b0;
      if (cs_fall_s) begin
         state_s = ST_CMD;
      end else if (cs_rise_s) begin
         // a byte completing together with CS release still lands as a write
         state_s  = ST_IDLE;
         wr_req_s = (state_r == ST_WRITE) && bus.RxDone_i;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_CMD: begin
               if (bus.RxDone_i) begin
                  cmd_load_s = 1'b1;
                  rd_req_s   = bus.RxData_i[7];
                  state_s    = bus.RxData_i[7] ? ST_READ_REQ : ST_WRITE;
               end else begin
                  state_s = ST_CMD;
               end
            end
            ST_WRITE: begin
               wr_req_s = bus.RxDone_i;
               state_s  = ST_WRITE;
            end
            ST_READ_REQ: begin
               state_s = ST_READ_LATCH;
            end
            ST_READ_LATCH: begin
               latch_s = 1'b1;
               state_s = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
               if (bus.RxDone_i) begin
                  rd_req_s = 1'b1;
                  state_s  = ST_READ_REQ;
               end else begin
                  state_s = ST_READ_WAIT;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Registered strobes, busy flag and CS history
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cs_r        <= 1'b1;
         reg_write_r <= 1'b0;
         reg_read_r  <= 1'b0;
         busy_r      <= 1'b0;
         wr_data_r   <= 8'h00;
      end else begin
         cs_r        <= bus.SyncCS_i;
         reg_write_r <= wr_req_s;
         reg_read_r  <= rd_req_s;
         busy_r      <= (state_s != ST_IDLE);
         if (wr_req_s) begin
            wr_data_r <= bus.RxData_i;
         end
      end
   end

   // Address: loaded by the command byte, stepped after each write or read latch
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         reg_addr_r <= 7'd0;
      end else if (cmd_load_s) begin
         reg_addr_r <= bus.RxData_i[6:0];
      end else if (latch_s || reg_write_r) begin
         reg_addr_r <= addr_step(reg_addr_r);
      end
   end

   // Shift-out byte and saturating per-frame byte counter
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         tx_data_r    <= STATUS_BYTE;
         byte_count_r <= 8'd0;
      end else begin
         if (cs_fall_s) begin
            tx_data_r <= STATUS_BYTE;
         end else if (latch_s) begin
            tx_data_r <= bus.RegRdData_i;
         end
         if (cs_fall_s) begin
            byte_count_r <= 8'd0;
         end else if (count_s && (byte_count_r != 8'hFF)) begin
            byte_count_r <= byte_count_r + 8'd1;
         end
      end
   end

   assign bus.TxData_o    = tx_data_r;
   assign bus.RegAddr_o   = reg_addr_r;
   assign bus.RegWrData_o = wr_data_r;
   assign bus.RegWrite_o  = reg_write_r;
   assign bus.RegRead_o   = reg_read_r;
   assign bus.Busy_o      = busy_r;
   assign bus.ByteCount_o = byte_count_r;

endmodule

// File: tb/tb_slave_spi_reg_ctrl.sv
// Directed bench: a table of whole frames with hand-computed strobe logs, then
// hand-written sequences for CS-edge collisions, mid-frame reset and saturation.
module tb_slave_spi_reg_ctrl;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       cs;
   logic       rx_done;
   logic [7:0] rx_data;
   logic [7:0] rd_data;

   always #5 Clock = ~Clock;

   slave_spi_reg_ctrl_if u_if ();
   slave_spi_reg_ctrl_if u_if_hold ();

   assign u_if.SyncCS_i         = cs;
   assign u_if.RxData_i         = rx_data;
   assign u_if.RxDone_i         = rx_done;
   assign u_if.RegRdData_i      = rd_data;
   assign u_if_hold.SyncCS_i    = cs;
   assign u_if_hold.RxData_i    = rx_data;
   assign u_if_hold.RxDone_i    = rx_done;
   assign u_if_hold.RegRdData_i = 8'h00;

   slave_spi_reg_ctrl u_dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (u_if.slave)
   );

   slave_spi_reg_ctrl #(.STATUS_BYTE(8'hA5), .AUTO_INC(32'd0)) u_dut_hold (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (u_if_hold.slave)
   );

   // byte i in bits [8*i +: 8]; events are {is_read, addr[6:0], data[7:0]}
   typedef struct packed {
      logic [31:0] bytes;
      logic [2:0]  n;
      logic [1:0]  n_ev;
      logic [47:0] evs;
      logic [39:0] txs;
      logic [7:0]  cnt;
   } frame_t;

   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          n_both = 0;
   logic [15:0] ev_q[$];
   logic [15:0] ev_hold_q[$];
   frame_t      tbl [0:5];
   frame_t      rst_frame;

   // register file model: read data appears only in the cycle after the strobe
   always_ff @(posedge Clock) begin
      rd_data <= u_if.RegRead_o ? ({1'b0, u_if.RegAddr_o} + 8'h40) : 8'hEE;
   end

   always @(negedge Clock) begin
      if (u_if.RegWrite_o) ev_q.push_back({1'b0, u_if.RegAddr_o, u_if.RegWrData_o});
      if (u_if.RegRead_o)  ev_q.push_back({1'b1, u_if.RegAddr_o, 8'h00});
      if (u_if.RegWrite_o && u_if.RegRead_o) n_both <= n_both + 1;
      if (u_if_hold.RegWrite_o) ev_hold_q.push_back({1'b0, u_if_hold.RegAddr_o, u_if_hold.RegWrData_o});
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ev_at(input int i);
      if (i < ev_q.size()) return {16'h0000, ev_q[i]};
      return 32'hDEAD_0000;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "/tx"},    {24'h0, u_if.TxData_o},    32'h0000_00A5);
      chk({tag, "/addr"},  {25'h0, u_if.RegAddr_o},   32'h0);
      chk({tag, "/wdata"}, {24'h0, u_if.RegWrData_o}, 32'h0);
      chk({tag, "/wr"},    {31'h0, u_if.RegWrite_o},  32'h0);
      chk({tag, "/rd"},    {31'h0, u_if.RegRead_o},   32'h0);
      chk({tag, "/cnt"},   {24'h0, u_if.ByteCount_o}, 32'h0);
      chk({tag, "/busy"},  {31'h0, u_if.Busy_o},      32'h0);
   endtask

   task automatic run_frame(input frame_t f, input string tag);
      ev_q.delete();
      ev_hold_q.delete();
      cs = 1'b0;
      tick();
      chk({tag, "/cnt_clr"}, {24'h0, u_if.ByteCount_o}, 32'h0);
      chk({tag, "/busy_on"}, {31'h0, u_if.Busy_o},      32'h1);
      repeat (2) tick();
      for (int i = 0; i < int'(f.n); i++) begin
         chk($sformatf("%s/tx%0d", tag, i), {24'h0, u_if.TxData_o}, {24'h0, f.txs[8*i +: 8]});
         send_byte(f.bytes[8*i +: 8], 7);
      end
      chk({tag, "/tx_end"}, {24'h0, u_if.TxData_o}, {24'h0, f.txs[8*int'(f.n) +: 8]});
      cs = 1'b1;
      repeat (3) tick();
      chk({tag, "/busy_off"}, {31'h0, u_if.Busy_o},      32'h0);
      chk({tag, "/cnt"},      {24'h0, u_if.ByteCount_o}, {24'h0, f.cnt});
      chk({tag, "/n_ev"},     ev_q.size(),               {30'h0, f.n_ev});
      for (int i = 0; i < int'(f.n_ev); i++) begin
         chk($sformatf("%s/ev%0d", tag, i), ev_at(i), {16'h0, f.evs[16*i +: 16]});
      end
   endtask

   initial begin
      tbl[0] = '{bytes: 32'h0000_0042, n: 3'd1, n_ev: 2'd0, evs: 48'h0,
                 txs: 40'h00_0000_A5A5, cnt: 8'd1};
      tbl[1] = '{bytes: 32'h0022_1105, n: 3'd3, n_ev: 2'd2, evs: 48'h0000_0622_0511,
                 txs: 40'h00_A5A5_A5A5, cnt: 8'd3};
      tbl[2] = '{bytes: 32'h0000_0090, n: 3'd3, n_ev: 2'd3, evs: 48'h9200_9100_9000,
                 txs: 40'h00_5251_50A5, cnt: 8'd3};
      tbl[3] = '{bytes: 32'hCCBB_AA7E, n: 3'd4, n_ev: 2'd3, evs: 48'h00CC_7FBB_7EAA,
                 txs: 40'hA5_A5A5_A5A5, cnt: 8'd4};
      tbl[4] = '{bytes: 32'h0000_00FF, n: 3'd2, n_ev: 2'd2, evs: 48'h0000_8000_FF00,
                 txs: 40'h00_0040_BFA5, cnt: 8'd2};
      tbl[5] = '{bytes: 32'h0002_017F, n: 3'd3, n_ev: 2'd2, evs: 48'h0000_0002_7F01,
                 txs: 40'h00_A5A5_A5A5, cnt: 8'd3};
      rst_frame = '{bytes: 32'h0000_AA03, n: 3'd2, n_ev: 2'd1, evs: 48'h0000_0000_03AA,
                    txs: 40'h00_00A5_A5A5, cnt: 8'd2};

      Reset   = 1'b0;
      cs      = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      repeat (2) tick();
      check_reset("reset");
      Reset = 1'b1;
      repeat (2) tick();

      for (int t = 0; t < 6; t++) begin
         run_frame(tbl[t], $sformatf("frame%0d", t));
      end
      chk("hold/n_wr", ev_hold_q.size(), 32'd2);
      chk("hold/wr0", (ev_hold_q.size() > 0) ? {16'h0, ev_hold_q[0]} : 32'hDEAD, 32'h7F01);
      chk("hold/wr1", (ev_hold_q.size() > 1) ? {16'h0, ev_hold_q[1]} : 32'hDEAD, 32'h7F02);

      // last data byte completes in the same cycle CS is released
      ev_q.delete();
      cs = 1'b0;
      repeat (3) tick();
      send_byte(8'h20, 7);
      rx_data = 8'h5A;
      rx_done = 1'b1;
      cs      = 1'b1;
      tick();
      rx_done = 1'b0;
      chk("wrcs/wr",    {31'h0, u_if.RegWrite_o},  32'h1);
      chk("wrcs/addr",  {25'h0, u_if.RegAddr_o},   32'h20);
      chk("wrcs/wdata", {24'h0, u_if.RegWrData_o}, 32'h5A);
      chk("wrcs/busy",  {31'h0, u_if.Busy_o},      32'h0);
      tick();
      chk("wrcs/wr_off", {31'h0, u_if.RegWrite_o}, 32'h0);
      chk("wrcs/addr+1", {25'h0, u_if.RegAddr_o},  32'h21);
      repeat (4) tick();
      chk("wrcs/n_wr", ev_q.size(), 32'd1);

      // dummy byte in READ_WAIT together with CS release: no further read
      ev_q.delete();
      cs = 1'b0;
      repeat (3) tick();
      send_byte(8'h85, 7);
      chk("rdcs/tx", {24'h0, u_if.TxData_o}, 32'h45);
      rx_data = 8'h00;
      rx_done = 1'b1;
      cs      = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat (6) tick();
      chk("rdcs/n_ev", ev_q.size(), 32'd1);
      chk("rdcs/ev0",  ev_at(0), 32'h8500);
      chk("rdcs/tx_hold", {24'h0, u_if.TxData_o}, 32'h45);
      chk("rdcs/busy", {31'h0, u_if.Busy_o}, 32'h0);

      // reset right after the command byte of a write frame
      ev_q.delete();
      cs = 1'b0;
      repeat (3) tick();
      send_byte(8'h09, 4);
      Reset = 1'b0;
      #1;
      check_reset("midrst");
      cs = 1'b1;
      repeat (2) tick();
      Reset = 1'b1;
      repeat (3) tick();
      chk("midrst/n_ev", ev_q.size(), 32'd0);
      check_reset("postrst");
      run_frame(rst_frame, "rstframe");

      // 300-byte write frame: count saturation and address wrap
      ev_q.delete();
      cs = 1'b0;
      repeat (3) tick();
      send_byte(8'h00, 3);
      for (int i = 1; i < 300; i++) begin
         send_byte(i[7:0], 3);
      end
      chk("long/cnt",  {24'h0, u_if.ByteCount_o}, 32'd255);
      chk("long/n_wr", ev_q.size(), 32'd299);
      chk("long/wr0",   ev_at(0),   32'h0001);
      chk("long/wr128", ev_at(128), 32'h0081);
      chk("long/wr298", ev_at(298), 32'h2A2B);
      chk("long/addr",  {25'h0, u_if.RegAddr_o}, 32'h2B);
      cs = 1'b1;
      repeat (3) tick();
      ev_q.delete();
      for (int i = 0; i < 3; i++) begin
         send_byte(8'h81, 3);
      end
      chk("idle/cnt",  {24'h0, u_if.ByteCount_o}, 32'd255);
      chk("idle/n_ev", ev_q.size(), 32'd0);
      chk("idle/busy", {31'h0, u_if.Busy_o}, 32'h0);
      chk("idle/tx",   {24'h0, u_if.TxData_o}, 32'hA5);

      chk("excl", n_both, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
